// File: rtl/falling_char_engine.sv
// Slot engine for falling characters: spawn allocation, per-tick fall, sequential hit scan,
// registered renderer read port and saturating hit/miss counters.
module falling_char_engine #(
    parameter int unsigned N_SLOTS  = 16,
    parameter int unsigned CHAR_W   = 8,
    parameter int unsigned X_W      = 7,
    parameter int unsigned Y_W      = 10,
    parameter int unsigned SPD_W    = 4,
    parameter int unsigned SCREEN_H = 480,
    parameter int unsigned CELL_H   = 16,
    parameter int unsigned CNT_W    = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       tick,
    input  logic                       spawn_valid,
    input  logic [CHAR_W-1:0]          spawn_char,
    input  logic [X_W-1:0]             spawn_x,
    input  logic [SPD_W-1:0]           spawn_speed,
    output logic                       spawn_ready,
    input  logic                       hit_valid,
    input  logic [CHAR_W-1:0]          hit_char,
    output logic                       hit_busy,
    output logic                       hit_done,
    output logic                       hit_found,
    output logic                       miss_pulse,
    input  logic [$clog2(N_SLOTS)-1:0] rd_idx,
    output logic                       rd_active,
    output logic [CHAR_W-1:0]          rd_char,
    output logic [X_W-1:0]             rd_x,
    output logic [Y_W-1:0]             rd_y,
    output logic [$clog2(N_SLOTS):0]   active_count,
    output logic [CNT_W-1:0]           hit_count,
    output logic [CNT_W-1:0]           miss_count
);

    localparam int unsigned IDX_W  = $clog2(N_SLOTS);
    localparam int unsigned NUM_W  = IDX_W + 1;
    localparam int unsigned SCAN_W = IDX_W + 1;

    typedef enum logic {IDLE, SCAN} hit_state_t;

    logic [N_SLOTS-1:0] active_q, active_d;
    logic [CHAR_W-1:0]  char_q [N_SLOTS];
    logic [CHAR_W-1:0]  char_d [N_SLOTS];
    logic [X_W-1:0]     x_q    [N_SLOTS];
    logic [X_W-1:0]     x_d    [N_SLOTS];
    logic [Y_W-1:0]     y_q    [N_SLOTS];
    logic [Y_W-1:0]     y_d    [N_SLOTS];
    logic [SPD_W-1:0]   spd_q  [N_SLOTS];
    logic [SPD_W-1:0]   spd_d  [N_SLOTS];

    hit_state_t         state_q, state_d;
    logic [SCAN_W-1:0]  scan_idx_q, scan_idx_d;
    logic [CHAR_W-1:0]  hit_char_q, hit_char_d;
    logic               best_valid_q, best_valid_d;
    logic [IDX_W-1:0]   best_idx_q, best_idx_d;
    logic [Y_W-1:0]     best_y_q, best_y_d;

    logic               hit_done_q, hit_done_d;
    logic               hit_found_q, hit_found_d;
    logic               miss_pulse_q, miss_pulse_d;
    logic [CNT_W-1:0]   hit_count_q, hit_count_d;
    logic [CNT_W-1:0]   miss_count_q, miss_count_d;
    logic               rd_active_q, rd_active_d;
    logic [CHAR_W-1:0]  rd_char_q, rd_char_d;
    logic [X_W-1:0]     rd_x_q, rd_x_d;
    logic [Y_W-1:0]     rd_y_q, rd_y_d;

    logic               spawn_ok;
    logic               spawn_fire;
    logic [IDX_W-1:0]   spawn_slot;
    logic [Y_W:0]       fall_y [N_SLOTS];
    logic [N_SLOTS-1:0] miss_vec;
    logic [NUM_W-1:0]   n_miss;
    logic [NUM_W-1:0]   n_active;
    logic               commit;
    logic               hit_ok;
    logic [IDX_W-1:0]   scan_slot;
    logic [CNT_W:0]     miss_sum;

    // Lowest-index slot that was free at the start of the cycle.
    always_comb begin
        spawn_ok   = 1'b0;
        spawn_slot = '0;
        for (int unsigned i = 0; i < N_SLOTS; i++) begin
            if (!active_q[i] && !spawn_ok) begin
                spawn_ok   = 1'b1;
                spawn_slot = IDX_W'(i);
            end
        end
    end

    assign spawn_fire = spawn_valid && spawn_ok;

    always_comb begin
        n_miss   = '0;
        n_active = '0;
        for (int unsigned i = 0; i < N_SLOTS; i++) begin
            fall_y[i]   = {1'b0, y_q[i]} + (Y_W+1)'(spd_q[i]);
            miss_vec[i] = tick && active_q[i] && ((32'(fall_y[i]) + CELL_H) > SCREEN_H);
            n_miss      = n_miss + NUM_W'(miss_vec[i]);
            n_active    = n_active + NUM_W'(active_q[i]);
        end
    end

    always_comb begin
        state_d      = state_q;
        scan_idx_d   = scan_idx_q;
        hit_char_d   = hit_char_q;
        best_valid_d = best_valid_q;
        best_idx_d   = best_idx_q;
        best_y_d     = best_y_q;
        commit       = 1'b0;
        scan_slot    = scan_idx_q[IDX_W-1:0];
        case (state_q)
            IDLE: begin
                if (hit_valid) begin
                    hit_char_d   = hit_char;
                    scan_idx_d   = '0;
                    best_valid_d = 1'b0;
                    best_idx_d   = '0;
                    best_y_d     = '0;
                    state_d      = SCAN;
                end
            end
            SCAN: begin
                if (scan_idx_q == SCAN_W'(N_SLOTS)) begin
                    commit  = 1'b1;
                    state_d = IDLE;
                end else begin
                    // Strictly-greater compare keeps the lower index on equal heights.
                    if (active_q[scan_slot] && (char_q[scan_slot] == hit_char_q) &&
                        (!best_valid_q || (y_q[scan_slot] > best_y_q))) begin
                        best_valid_d = 1'b1;
                        best_idx_d   = scan_slot;
                        best_y_d     = y_q[scan_slot];
                    end
                    scan_idx_d = scan_idx_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // A miss on the committed slot wins over the hit.
    assign hit_ok = commit && best_valid_q && active_q[best_idx_q] &&
                    (char_q[best_idx_q] == hit_char_q) && !miss_vec[best_idx_q];

    always_comb begin
        active_d = active_q;
        char_d   = char_q;
        x_d      = x_q;
        y_d      = y_q;
        spd_d    = spd_q;
        for (int unsigned i = 0; i < N_SLOTS; i++) begin
            if (active_q[i]) begin
                if (miss_vec[i] || (hit_ok && (best_idx_q == IDX_W'(i)))) begin
                    active_d[i] = 1'b0;
                    char_d[i]   = '0;
                    x_d[i]      = '0;
                    y_d[i]      = '0;
                    spd_d[i]    = '0;
                end else if (tick) begin
                    y_d[i] = fall_y[i][Y_W-1:0];
                end
            end else if (spawn_fire && (spawn_slot == IDX_W'(i))) begin
                active_d[i] = 1'b1;
                char_d[i]   = spawn_char;
                x_d[i]      = spawn_x;
                y_d[i]      = '0;
                spd_d[i]    = (spawn_speed == '0) ? SPD_W'(1) : spawn_speed;
            end
        end
    end

    always_comb begin
        hit_done_d   = commit;
        hit_found_d  = hit_ok;
        miss_pulse_d = |miss_vec;
        hit_count_d  = (hit_ok && (hit_count_q != '1)) ? hit_count_q + 1'b1 : hit_count_q;
        miss_sum     = {1'b0, miss_count_q} + (CNT_W+1)'(n_miss);
        miss_count_d = miss_sum[CNT_W] ? '1 : miss_sum[CNT_W-1:0];
        rd_active_d  = 1'b0;
        rd_char_d    = '0;
        rd_x_d       = '0;
        rd_y_d       = '0;
        if (32'(rd_idx) < N_SLOTS) begin
            rd_active_d = active_q[rd_idx];
            rd_char_d   = char_q[rd_idx];
            rd_x_d      = x_q[rd_idx];
            rd_y_d      = y_q[rd_idx];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            active_q     <= '0;
            for (int unsigned i = 0; i < N_SLOTS; i++) begin
                char_q[i] <= '0;
                x_q[i]    <= '0;
                y_q[i]    <= '0;
                spd_q[i]  <= '0;
            end
            state_q      <= IDLE;
            scan_idx_q   <= '0;
            hit_char_q   <= '0;
            best_valid_q <= 1'b0;
            best_idx_q   <= '0;
            best_y_q     <= '0;
            hit_done_q   <= 1'b0;
            hit_found_q  <= 1'b0;
            miss_pulse_q <= 1'b0;
            hit_count_q  <= '0;
            miss_count_q <= '0;
            rd_active_q  <= 1'b0;
            rd_char_q    <= '0;
            rd_x_q       <= '0;
            rd_y_q       <= '0;
        end else begin
            active_q     <= active_d;
            char_q       <= char_d;
            x_q          <= x_d;
            y_q          <= y_d;
            spd_q        <= spd_d;
            state_q      <= state_d;
            scan_idx_q   <= scan_idx_d;
            hit_char_q   <= hit_char_d;
            best_valid_q <= best_valid_d;
            best_idx_q   <= best_idx_d;
            best_y_q     <= best_y_d;
            hit_done_q   <= hit_done_d;
            hit_found_q  <= hit_found_d;
            miss_pulse_q <= miss_pulse_d;
            hit_count_q  <= hit_count_d;
            miss_count_q <= miss_count_d;
            rd_active_q  <= rd_active_d;
            rd_char_q    <= rd_char_d;
            rd_x_q       <= rd_x_d;
            rd_y_q       <= rd_y_d;
        end
    end

    assign spawn_ready  = spawn_ok;
    assign hit_busy     = (state_q == SCAN);
    assign hit_done     = hit_done_q;
    assign hit_found    = hit_found_q;
    assign miss_pulse   = miss_pulse_q;
    assign rd_active    = rd_active_q;
    assign rd_char      = rd_char_q;
    assign rd_x         = rd_x_q;
    assign rd_y         = rd_y_q;
    assign active_count = n_active;
    assign hit_count    = hit_count_q;
    assign miss_count   = miss_count_q;

endmodule

// File: doc/falling_char_engine.md
Name: falling_char_engine

Overview:
Parametrised slot engine for the typing game's falling characters. It holds N_SLOTS independent character objects, each with an active flag, character code, column, vertical pixel position and speed. It advances every active object on a move tick and allocates new objects from the character generator through a valid/ready spawn port. It resolves keypress hits with a sequential scan, and exposes a registered per-slot read port to the VGA renderer. Hit and miss counts are kept internally.

Parameters:
N_SLOTS, 16, number of object slots (2..64)
CHAR_W, 8, character code width (ASCII)
X_W, 7, column index width in character cells (80 columns)
Y_W, 10, vertical pixel position width
SPD_W, 4, speed width in pixels per tick
SCREEN_H, 480, visible screen height in pixels
CELL_H, 16, glyph height in pixels
CNT_W, 16, width of hit/miss counters

Ports:
clk  in  1  system clock
rst  in  1  asynchronous active-high reset
tick  in  1  one-cycle move strobe (from moveable divider, pre-synchronised)
spawn_valid  in  1  generator offers a new object
spawn_char  in  CHAR_W  character code
spawn_x  in  X_W  column
spawn_speed  in  SPD_W  pixels per tick
spawn_ready  out  1  a free slot exists
hit_valid  in  1  keypress strobe
hit_char  in  CHAR_W  pressed character
hit_busy  out  1  hit scan in progress
hit_done  out  1  one-cycle scan-complete pulse
hit_found  out  1  valid with hit_done: a slot was cleared
miss_pulse  out  1  one or more objects fell off screen this cycle
rd_idx  in  log2(N_SLOTS)  renderer slot select
rd_active  out  1  slot state, 1-cycle latency
rd_char  out  CHAR_W  slot character, 1-cycle latency
rd_x  out  X_W  slot column, 1-cycle latency
rd_y  out  Y_W  slot vertical position, 1-cycle latency
active_count  out  log2(N_SLOTS)+1  number of active slots
hit_count  out  CNT_W  saturating hit total
miss_count  out  CNT_W  saturating miss total

Behaviour:
- Reset (async, rst=1): all slots inactive with fields 0; FSM=IDLE; all outputs 0 except spawn_ready=1.
- Spawn:
  - Accepted when spawn_valid and spawn_ready.
  - Allocates the lowest-index slot that was free at the start of the cycle: active=1, y=0, char/x latched; speed=spawn_speed, with 0 forced to 1.
  - spawn_ready = any slot free (combinational from registered state).
  - A slot freed this cycle is not reusable until the next cycle.
- Move, on tick:
  - Every active slot, excluding one spawned this same cycle, computes y+speed in Y_W+1 bits.
  - If (y+speed)+CELL_H > SCREEN_H: slot goes inactive, miss_count increments once per freed slot (saturating at all-ones), and miss_pulse=1 for that cycle.
  - Otherwise y <= y+speed.
  - All slots update in parallel, in one cycle.
- Hit FSM, states IDLE and SCAN:
  - IDLE: hit_valid accepts hit_char into a register, sets scan idx=0 and best=none, and moves to SCAN. hit_busy=1 from the next cycle.
  - SCAN: one slot per cycle. A candidate is an active slot with char equal to the latched hit_char and y strictly greater than the current best; equal y keeps the lower index.
  - After slot N_SLOTS-1 is examined, commit:
    - If best exists, is still active, and its char still matches: clear it, hit_count++ (saturating), hit_found=1.
    - Else hit_found=0.
    - hit_done=1 in the commit cycle, then return to IDLE.
  - Latency: hit_done is asserted N_SLOTS+1 cycles after the accept edge.
  - hit_valid while busy is ignored, not queued.
- Simultaneous events:
  - tick during SCAN: moves still apply. A best slot freed as a miss before commit gives hit_found=0 and no double count.
  - Commit clear and tick-miss on the same slot in the same cycle: counts as a miss, not a hit.
  - Spawn in the commit cycle may not target the committed slot.
- active_count reflects registered state.
- Read port: registered, always available; rd_idx ≥ N_SLOTS returns zeros.

Test Plan:
- Reset, then spawn 'A' (0x41) x=5 speed=4 -> slot0 active; rd_idx=0 gives char 0x41, x=5, y=0 one cycle later; active_count=1.
- Slot0 speed 4, apply 116 ticks -> y=464; next tick (468+16>480) -> slot0 freed, miss_pulse=1, miss_count=1, active_count=0.
- Fill all 16 slots -> spawn_ready=0 and a 17th spawn_valid is ignored. One miss frees slot 3 -> next spawn lands in slot 3.
- Hit 'B' with 'B' in slot2 y=100 and slot7 y=200 -> hit_done 17 cycles after accept, hit_found=1, slot7 cleared, slot2 kept, hit_count=1. A second hit_valid during the scan is ignored.
- Hit 'Z' with no 'Z' on screen -> hit_done with hit_found=0, hit_count unchanged.
- Best candidate at y=460 speed 8 and tick mid-scan -> slot misses, hit_found=0, miss_count+1, hit_count unchanged. Assert rst mid-scan -> immediate IDLE, all slots cleared.
